seq_pipe_add2_nstage: RTL and testbench
=======================================

Name: seq_pipe_add2_nstage

Overview:
- Parametrised successor to the single-stage pipelined two-input adder.
- Adds two NBITS operands and delivers the sum after NSTAGES register stages.
- Full valid/ready flow control: independent back-pressure per stage, with bubble collapsing.
- Flags signed overflow per result; sits between streaming producers and consumers in datapath test harnesses.

Parameters:
- NBITS, 8, operand/result width; legal range ≥ 2.
- NSTAGES, 2, number of pipeline register stages; legal range ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in0  input  NBITS  operand A, two's complement.
- in1  input  NBITS  operand B, two's complement.
- in_val  input  1  operands valid.
- in_rdy  output  1  block can accept operands this cycle.
- out  output  NBITS  result of stage NSTAGES-1.
- out_ovf  output  1  signed overflow flag travelling with out.
- out_val  output  1  out/out_ovf valid.
- out_rdy  input  1  consumer accepts result this cycle.

Behaviour:
- Reset state:
  - reset_n low clears all stage valid bits, data registers and ovf registers to 0, immediately and independent of clk.
  - While reset_n is low: out_val=0, out=0, out_ovf=0, in_rdy=1.
- Arithmetic (combinational, before stage 0):
  - sum = (in0 + in1) mod 2^NBITS.
  - ovf = (in0[MSB]==in1[MSB]) && (sum[MSB]!=in0[MSB]).
  - The carry-out is discarded.
- Stage k (0..NSTAGES-1) holds {val_k, data_k, ovf_k}. Stage NSTAGES-1 drives out, out_ovf and out_val.
- Advance rules:
  - go_last = out_rdy || !val_last.
  - go_k = !val_k || go_{k+1}, for k < NSTAGES-1.
  - in_rdy = go_0. This is combinational, from out_rdy through the chain. No registered ready.
- On a rising edge with go_k:
  - Stage k loads stage k-1 (stage 0 loads the adder output).
  - val_k takes val_{k-1} (stage 0 takes in_val).
  - When stage k-1 is empty, stage k becomes invalid. Data registers may load don't-care values only if their val bit is 0.
- Without go_k, stage k holds all fields.
- Transfer events:
  - Input transfer: in_val && in_rdy on an edge.
  - Output transfer: out_val && out_rdy on an edge.
- Latency and throughput:
  - Latency is exactly NSTAGES cycles with out_rdy held high: an input accepted at edge n appears with out_val=1 after edge n+NSTAGES-1 and is consumed at edge n+NSTAGES.
  - Throughput is 1 result/cycle.
- Stalls:
  - When out_rdy=0 and all stages are valid, in_rdy=0 and the contents are frozen.
  - When out_rdy=0 and a bubble exists, upstream stages still advance into the bubble, so in_rdy=1 until the pipe fills.
  - Full pipe plus out_rdy=1: simultaneous input and output transfers on the same edge. No loss, no duplication.
- Invariants:
  - Results emerge strictly in acceptance order.
  - in_val with in_rdy=0 is not a transfer. The producer holds its operands.
  - out values do not change while out_val=1 and out_rdy=0.
- Reset mid-operation discards all in-flight results. out_val=0 on the first cycle after reset_n rises.
- NSTAGES=1 degenerates to a single register with in_rdy = out_rdy || !out_val.

Optional Feature:
- Macro: SEQ_PIPE_ADD2_NSTAGE_SAT_EN.
- Defined: on ovf, stage 0 loads the saturated value instead of the wrapped sum:
  - 2^(NBITS-1)-1 when in0 is non-negative.
  - -2^(NBITS-1) when in0 is negative.
  - out_ovf still reports 1.
- Undefined: wrap-around sum as above.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- NBITS=8, NSTAGES=2, out_rdy=1, stream (42,13),(13,42),(100,27) back-to-back -> out_val rises 2 cycles after first accept; out=55,55,127 on consecutive cycles, out_ovf=0.
- Overflow: (127,1),(-128,-1),(-120,-13) -> wrap build: out=0x80,0x7F,0x7B with out_ovf=1,1,1; SAT build: 0x7F,0x80,0x80 with out_ovf=1,1,1.
- Back-pressure: fill with 4 inputs while out_rdy=0 -> in_rdy drops to 0 after 2 accepts; out holds first result stable; raise out_rdy -> remaining results drain in order with no loss or duplication.
- Bubble collapse: accept 1 input, idle 1 cycle, accept 1 input, out_rdy=0 -> both stages valid and in_rdy=0 after the second accept; release out_rdy -> outputs in acceptance order.
- Async reset: assert reset_n=0 mid-cycle with 2 valid results in flight -> out_val=0, out=0, in_rdy=1 immediately with no clk edge; after release, no stale results appear.
- Random: NSTAGES in {1,3,4}, 50 random operand pairs with random in_val/out_rdy -> output sequence matches a golden queue model (sum mod 256, ovf rule).

Source files
------------

// File: rtl/seq_pipe_add2_nstage.sv
// NSTAGES-deep valid/ready pipelined signed adder with overflow flag; optional saturation via SEQ_PIPE_ADD2_NSTAGE_SAT_EN.
// Latency NSTAGES cycles, 1 result/cycle; a stage advances when empty or when its successor advances, so bubbles collapse under stall.
module seq_pipe_add2_nstage #(
  parameter int NBITS   = 8,
  parameter int NSTAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [NBITS-1:0] out,
  output logic             out_ovf,
  output logic             out_val,
  input  logic             out_rdy
);

  typedef struct packed {
    logic             ovf;
    logic [NBITS-1:0] dat;
  } stage_t;

  stage_t             stg_q [NSTAGES];
  logic [NSTAGES-1:0] vld_q;
  logic [NSTAGES-1:0] go;
  logic [NBITS-1:0]   sum;
  logic               ovf;
  stage_t             stg_d0;
  logic               go_acc;

  assign sum = in0 + in1;
  assign ovf = (in0[NBITS-1] == in1[NBITS-1]) && (sum[NBITS-1] != in0[NBITS-1]);

  always_comb begin
    stg_d0.ovf = ovf;
    stg_d0.dat = sum;
`ifdef SEQ_PIPE_ADD2_NSTAGE_SAT_EN
    if (ovf) begin
      stg_d0.dat = in0[NBITS-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    end
`endif
  end

  // Ready ripples back from the consumer through a scalar accumulator to keep the chain acyclic.
  always_comb begin
    go_acc            = out_rdy || !vld_q[NSTAGES-1];
    go                = '0;
    go[NSTAGES-1]     = go_acc;
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      go_acc = !vld_q[k] || go_acc;
      go[k]  = go_acc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      if (go[0]) begin
        vld_q[0] <= in_val;
        stg_q[0] <= stg_d0;
      end
      for (int k = 1; k < NSTAGES; k++) begin
        if (go[k]) begin
          vld_q[k] <= vld_q[k-1];
          stg_q[k] <= stg_q[k-1];
        end
      end
    end
  end

  assign in_rdy  = go[0];
  assign out     = stg_q[NSTAGES-1].dat;
  assign out_ovf = stg_q[NSTAGES-1].ovf;
  assign out_val = vld_q[NSTAGES-1];

endmodule

// File: tb/tb_seq_pipe_add2_nstage.sv
// Self-checking bench: four adders (NSTAGES 2,1,3,4) against a queue-based reference model.
module tb_seq_pipe_add2_nstage;

  logic       clk;
  logic       rst_n;
  logic [7:0] a    [4];
  logic [7:0] b    [4];
  logic       iv   [4];
  logic       ir   [4];
  logic [7:0] o    [4];
  logic       ov   [4];
  logic       oval [4];
  logic       ordy [4];

  int         chk;
  int         err;
  logic [8:0] mem  [4][512];
  int         wp   [4];
  int         rp   [4];
  logic       acc  [4];
  logic       hold_v [4];
  logic [7:0] hold_o [4];
  int         cnt  [4];

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int NS = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
    seq_pipe_add2_nstage #(.NBITS(8), .NSTAGES(NS)) u_dut (
      .clk     (clk),
      .reset_n (rst_n),
      .in0     (a[g]),
      .in1     (b[g]),
      .in_val  (iv[g]),
      .in_rdy  (ir[g]),
      .out     (o[g]),
      .out_ovf (ov[g]),
      .out_val (oval[g]),
      .out_rdy (ordy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer add, overflow if outside [-128,127].
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
    int sx, sy, s;
    logic [7:0] r;
    logic f;
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy;
    f  = (s > 127) || (s < -128);
    r  = s[7:0];
`ifdef SEQ_PIPE_ADD2_NSTAGE_SAT_EN
    if (f) r = (s > 0) ? 8'h7F : 8'h80;
`endif
    return {f, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input logic [7:0] x, input logic [7:0] y, input logic v);
    a[i]  = x;
    b[i]  = y;
    iv[i] = v;
  endtask

  // Sample mid-cycle, score transfers for the coming edge, then advance one cycle.
  task automatic tick();
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hold_v[i]) begin
        check("hold_val", oval[i], 1);
        check("hold_out", o[i], hold_o[i]);
      end
      hold_v[i] = oval[i] && !ordy[i];
      hold_o[i] = o[i];
      acc[i]    = iv[i] && ir[i];
      if (oval[i] && ordy[i]) begin
        check("out_expected", (wp[i] != rp[i]), 1);
        if (wp[i] != rp[i]) begin
          check("out_dat", {ov[i], o[i]}, mem[i][rp[i] % 512]);
          rp[i]++;
        end
      end
      if (acc[i]) begin
        mem[i][wp[i] % 512] = model(a[i], b[i]);
        wp[i]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    while (n < 50 && (wp[0] != rp[0] || wp[1] != rp[1] || wp[2] != rp[2] || wp[3] != rp[3])) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) check("drain_empty", wp[i] - rp[i], 0);
  endtask

  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [7:0] e_ov [3];
  int idx;
  int cyc;

  initial begin
    chk = 0;
    err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(i, 8'h00, 8'h00, 1'b0);
      ordy[i] = 1'b1; wp[i] = 0; rp[i] = 0; acc[i] = 1'b0;
      hold_v[i] = 1'b0; hold_o[i] = 8'h00; cnt[i] = 0;
    end
    #3;
    for (int i = 0; i < 4; i++) begin
      check("rst_out_val", oval[i], 0);
      check("rst_out", o[i], 0);
      check("rst_ovf", ov[i], 0);
      check("rst_in_rdy", ir[i], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream, latency 2 on the NSTAGES=2 instance.
    drv(0, 8'd42, 8'd13, 1'b1); tick();
    check("lat_first_empty", oval[0], 0);
    drv(0, 8'd13, 8'd42, 1'b1); tick();
    check("lat_second_val", oval[0], 1);
    check("stream_sum0", o[0], 55);
    check("stream_ovf0", ov[0], 0);
    drv(0, 8'd100, 8'd27, 1'b1); tick();
    check("stream_sum1", o[0], 55);
    iv[0] = 1'b0; tick();
    check("stream_sum2", o[0], 127);
    check("stream_ovf2", ov[0], 0);
    tick(); tick();
    check("stream_idle", oval[0], 0);

    // Overflow corners.
`ifdef SEQ_PIPE_ADD2_NSTAGE_SAT_EN
    e_ov[0] = 8'h7F; e_ov[1] = 8'h80; e_ov[2] = 8'h80;
`else
    e_ov[0] = 8'h80; e_ov[1] = 8'h7F; e_ov[2] = 8'h7B;
`endif
    drv(0, 8'h7F, 8'h01, 1'b1); tick();
    drv(0, 8'h80, 8'hFF, 1'b1); tick();
    check("ovf_out0", o[0], e_ov[0]); check("ovf_flag0", ov[0], 1);
    drv(0, 8'h88, 8'hF3, 1'b1); tick();
    check("ovf_out1", o[0], e_ov[1]); check("ovf_flag1", ov[0], 1);
    iv[0] = 1'b0; tick();
    check("ovf_out2", o[0], e_ov[2]); check("ovf_flag2", ov[0], 1);
    drain();

    // Back-pressure: only two accepts fit while the consumer stalls.
    pa[0] = 8'd1; pb[0] = 8'd2; pa[1] = 8'd3; pb[1] = 8'd4;
    pa[2] = 8'd5; pb[2] = 8'd6; pa[3] = 8'd7; pb[3] = 8'd8;
    ordy[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drv(0, pa[idx], pb[idx], 1'b1);
      tick();
      if (acc[0]) idx++;
    end
    check("bp_accepts", idx, 2);
    check("bp_in_rdy", ir[0], 0);
    check("bp_out_val", oval[0], 1);
    check("bp_out_first", o[0], 3);
    ordy[0] = 1'b1;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      drv(0, pa[idx], pb[idx], 1'b1);
      tick();
      if (acc[0]) idx++;
      cyc++;
    end
    check("bp_all_accepted", idx, 4);
    drain();

    // Bubble collapse under stall.
    ordy[0] = 1'b0;
    drv(0, 8'd9, 8'd9, 1'b1); tick();
    iv[0] = 1'b0; tick();
    drv(0, 8'd10, 8'd10, 1'b1);
    #1 check("bub_rdy_before", ir[0], 1);
    tick();
    check("bub_accepted", acc[0], 1);
    iv[0] = 1'b0;
    #1 check("bub_full_rdy", ir[0], 0);
    check("bub_out_val", oval[0], 1);
    check("bub_out_first", o[0], 18);
    drain();

    // Asynchronous reset with two results in flight.
    ordy[0] = 1'b0;
    drv(0, 8'd20, 8'd20, 1'b1); tick();
    drv(0, 8'd30, 8'd30, 1'b1); tick();
    iv[0] = 1'b0;
    check("ar_pre_val", oval[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_val", oval[0], 0);
    check("ar_out", o[0], 0);
    check("ar_ovf", ov[0], 0);
    check("ar_in_rdy", ir[0], 1);
    for (int i = 0; i < 4; i++) begin
      rp[i] = wp[i];
      hold_v[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ar_no_stale", oval[0], 0);
    end

    // Random traffic on all four depths.
    cyc = 0;
    for (int i = 0; i < 4; i++) acc[i] = 1'b0;
    while ((cnt[0] < 50 || cnt[1] < 50 || cnt[2] < 50 || cnt[3] < 50) && cyc < 3000) begin
      for (int i = 0; i < 4; i++) begin
        if (!(iv[i] && !acc[i])) begin
          if (cnt[i] < 50) drv(i, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
          else iv[i] = 1'b0;
        end
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
      cyc++;
    end
    for (int i = 0; i < 4; i++) check("rand_accepts", cnt[i], 50);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
